// File: rtl/snd_pkg.sv
// Shared sound-unit widths and types.
// Used by the envelope, length counter and sweep units.
package snd_pkg;

  localparam int VOL_W_DEF    = 4;
  localparam int PERIOD_W_DEF = 3;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_e;

endpackage

// File: rtl/env_period_timer.sv
// Auto-reloading tick-period timer.
// Shared by the envelope and frequency-sweep units.
module env_period_timer
  import snd_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                tick,
  input  logic                enable,
  output logic                expire
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;

  // load masks the tick so a same-cycle trigger never steps
  assign expire = tick && enable && !load && (cnt <= ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      reload <= '0;
    end else if (load) begin
      cnt    <= load_val;
      reload <= load_val;
    end else if (tick && enable) begin
      cnt <= expire ? reload : cnt - ONE;
    end
  end

endmodule

// File: rtl/envelope_generator.sv
// Volume envelope for one sound channel.
// Config is latched at trigger; steps stop at the rail.
module envelope_generator
  import snd_pkg::*;
#(
  parameter int VOL_W    = VOL_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                env_tick,
  input  logic                trigger,
  input  logic                envelope_add,
  input  logic [PERIOD_W-1:0] period,
  input  logic [VOL_W-1:0]    starting_volume,
  output logic [VOL_W-1:0]    volume,
  output logic                env_active,
  output logic                dac_enable
);

  localparam logic [VOL_W-1:0] MAX_VOL = '1;
  localparam logic [VOL_W-1:0] ONE     = VOL_W'(1);

  env_dir_e         add_q;
  logic             expire;
  logic             start_rail;
  logic [VOL_W-1:0] rail;
  logic [VOL_W-1:0] vol_nxt;

  assign dac_enable = (starting_volume != '0) || envelope_add;

  assign start_rail = envelope_add ? (starting_volume == MAX_VOL)
                                   : (starting_volume == '0);

  assign rail    = (add_q == ENV_UP) ? MAX_VOL : '0;
  assign vol_nxt = (add_q == ENV_UP) ? volume + ONE : volume - ONE;

  env_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (trigger),
    .load_val (period),
    .tick     (env_tick),
    .enable   (env_active),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      volume     <= '0;
      env_active <= 1'b0;
      add_q      <= ENV_DOWN;
    end else if (trigger) begin
      volume     <= starting_volume;
      add_q      <= env_dir_e'(envelope_add);
      env_active <= (period != '0) && dac_enable && !start_rail;
    end else if (expire) begin
      volume <= vol_nxt;
      if (vol_nxt == rail)
        env_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_envelope_generator.sv
// Self-checking bench for envelope_generator.
// Directed scenarios plus randomized traffic against a model.
module tb_envelope_generator;

  localparam int VW   = 4;
  localparam int PW   = 3;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          env_tick;
  logic          trigger;
  logic          envelope_add;
  logic [PW-1:0] period;
  logic [VW-1:0] starting_volume;
  logic [VW-1:0] volume;
  logic          env_active;
  logic          dac_enable;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_vol = 0;
  int m_act = 0;
  int m_add = 0;
  int m_per = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  envelope_generator #(
    .VOL_W    (VW),
    .PERIOD_W (PW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .env_tick        (env_tick),
    .trigger         (trigger),
    .envelope_add    (envelope_add),
    .period          (period),
    .starting_volume (starting_volume),
    .volume          (volume),
    .env_active      (env_active),
    .dac_enable      (dac_enable)
  );

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", n, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit tr, input bit tk);
    reset    = r;
    trigger  = tr;
    env_tick = tk;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    trigger  = 1'b0;
    env_tick = 1'b0;
  endtask

  task automatic cfg(input bit a, input int p, input int s);
    envelope_add    = a;
    period          = PW'(p);
    starting_volume = VW'(s);
  endtask

  // Model: count ticks since the last step; step every m_per ticks
  always @(posedge clk) begin : model
    int v, a, c;
    v = m_vol;
    a = m_act;
    c = m_cnt;
    if (reset) begin
      v = 0; a = 0; c = 0;
      m_add <= 0;
      m_per <= 0;
    end else if (trigger) begin
      v = int'(starting_volume);
      c = 0;
      m_add <= int'(envelope_add);
      m_per <= int'(period);
      a = (period != 0) && (starting_volume != 0 || envelope_add)
          && !(envelope_add ? (starting_volume == MAXV)
                            : (starting_volume == 0));
    end else if (env_tick && a != 0) begin
      c = c + 1;
      if (c >= m_per) begin
        c = 0;
        v = (m_add != 0) ? v + 1 : v - 1;
        if (v == ((m_add != 0) ? MAXV : 0))
          a = 0;
      end
    end
    m_vol <= v;
    m_act <= a;
    m_cnt <= c;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("volume", 32'(volume), 32'(m_vol));
      check("env_active", 32'(env_active), 32'(m_act));
      check("dac_enable", 32'(dac_enable),
            32'((starting_volume != 0) || envelope_add));
    end
  end

  initial begin
    reset = 1'b1;
    trigger = 1'b0;
    env_tick = 1'b0;
    cfg(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk_en = 1'b1;
    check("rst_vol", 32'(volume), 0);
    check("rst_act", 32'(env_active), 0);

    // up to rail
    cfg(1, 2, 12);
    cyc(0, 1, 0);
    check("up_load", 32'(volume), 12);
    check("up_act0", 32'(env_active), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      if (i == 1) check("up_t1", 32'(volume), 12);
      if (i == 2) check("up_t2", 32'(volume), 13);
      if (i == 4) check("up_t4", 32'(volume), 14);
      if (i == 5) check("up_act5", 32'(env_active), 1);
      if (i == 6) check("up_t6", 32'(volume), 15);
      if (i == 6) check("up_act6", 32'(env_active), 0);
      if (i == 8) check("up_t8", 32'(volume), 15);
    end

    // down to rail
    cfg(0, 1, 3);
    cyc(0, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 1);
      if (i <= 3) check("dn_vol", 32'(volume), 32'(3 - i));
      if (i == 2) check("dn_act2", 32'(env_active), 1);
      if (i == 3) check("dn_act3", 32'(env_active), 0);
      if (i == 5) check("dn_t5", 32'(volume), 0);
    end

    // frozen, then DAC off
    cfg(1, 0, 7);
    cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    check("frz_vol", 32'(volume), 7);
    check("frz_act", 32'(env_active), 0);
    cfg(0, 0, 0);
    #1;
    check("dac_off", 32'(dac_enable), 0);
    cyc(0, 1, 0);
    check("off_vol", 32'(volume), 0);
    check("off_act", 32'(env_active), 0);

    // config latch and retrigger
    cfg(0, 3, 8);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("lat_t2", 32'(volume), 8);
    cfg(1, 1, 8);
    cyc(0, 0, 1);
    check("lat_t3", 32'(volume), 7);
    cyc(0, 1, 0);
    check("rtg_load", 32'(volume), 8);
    cyc(0, 0, 1);
    check("rtg_t1", 32'(volume), 9);
    cyc(0, 0, 1);
    check("rtg_t2", 32'(volume), 10);

    // collisions
    cyc(0, 1, 1);
    check("trg_tick", 32'(volume), 8);
    cyc(0, 0, 1);
    check("trg_next", 32'(volume), 9);
    cyc(1, 1, 0);
    check("rst_trg_v", 32'(volume), 0);
    check("rst_trg_a", 32'(env_active), 0);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    check("mid_step", 32'(volume), 9);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("mid_rst_v", 32'(volume), 0);
    check("mid_rst_a", 32'(env_active), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cfg(1'($urandom), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 15)));
      cyc(($urandom % 97) == 0, ($urandom % 24) == 0,
          ($urandom % 3) == 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_generator.md
Name: envelope_generator

Overview:
- Parametrised volume-envelope unit for one sound channel (square 1/2, noise).
- Loads a starting volume on trigger, then steps it up or down by one every `period` envelope ticks until it reaches a rail.
- The ticks come from the frame sequencer's 64 Hz envelope strobe.
- Envelope config is latched at trigger, so register writes mid-note do not disturb a running envelope.
- Feeds the channel DAC/mixer volume input.

Parameters:
VOL_W, 4, volume width; MAX_VOL = 2**VOL_W - 1
PERIOD_W, 3, envelope period width; period value 0 = envelope frozen

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
env_tick  input  1  single-cycle envelope strobe from frame sequencer
trigger  input  1  single-cycle note trigger
envelope_add  input  1  direction: 1 = increment, 0 = decrement (live register value)
period  input  PERIOD_W  steps between volume changes, in env_tick units (live register value)
starting_volume  input  VOL_W  initial volume (live register value)
volume  output  VOL_W  current envelope volume (registered)
env_active  output  1  envelope still stepping (registered)
dac_enable  output  1  combinational: (starting_volume != 0) || envelope_add

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: volume=0, env_active=0, period_cnt=0, add_q=0, period_q=0.
- Reset priority: reset dominates everything in the same cycle, including trigger.
- State: add_q and period_q (config latched at trigger), period_cnt[PERIOD_W], volume, env_active.
- Trigger (priority over env_tick in the same cycle):
  - volume<=starting_volume; add_q<=envelope_add; period_q<=period; period_cnt<=period.
  - env_active<=1 only if all hold: period!=0, dac_enable, and NOT at the rail (not envelope_add&&starting_volume==MAX_VOL, not !envelope_add&&starting_volume==0).
  - Otherwise env_active<=0.
- Trigger with dac_enable=0: volume loads 0, env_active=0.
- env_tick while env_active=1, trigger=0:
  - period_cnt>1: period_cnt<=period_cnt-1; volume holds.
  - period_cnt<=1 (expiry): period_cnt<=period_q. volume<=volume+1 if add_q, else volume-1.
  - If the new volume equals the rail (MAX_VOL for add, 0 for subtract), env_active<=0 in that same cycle.
- env_tick while env_active=0: no state change.
- Cycles without env_tick: no state change.
- Step latency: the first step lands on the period-th env_tick after trigger. volume is updated on the clock edge that samples that tick.
- Arithmetic: unsigned, VOL_W bits. Wrap-around is impossible by construction; a step is never taken at a rail.
- Live config writes (envelope_add, period, starting_volume) while env_active=1 have no effect until the next trigger.
  - Exception: dac_enable tracks them combinationally.
- Retrigger mid-envelope: full reload, as for a first trigger. The prior countdown is discarded.

Decomposition:
- Shared package snd_pkg:
  - Default widths: VOL_W_DEF=4, PERIOD_W_DEF=3.
  - Shared by the length counter and sweep unit.
- One sub-module, env_period_timer (PERIOD_W):
  - Inputs: clk, reset, load, load_val, tick, enable.
  - Output: expire, a one-cycle pulse on the tick where the count is <=1; the timer auto-reloads from the latched value on that tick.
  - The same timer is reused by the frequency-sweep unit.
- Top level holds volume, rail detection, env_active and dac_enable.

Test Plan:
- Up to rail: start=4'hC, add=1, period=2, trigger, then 8 env_ticks -> volume C→D (tick 2), E (tick 4), F (tick 6); env_active falls with the F update; ticks 7-8 leave F.
- Down to rail: start=3, add=0, period=1, 5 ticks -> volume 2, 1, 0; env_active=0 on the tick that writes 0; stays 0.
- Frozen and DAC-off: period=0, start=7, trigger, 10 ticks -> volume stays 7, env_active=0. Then start=0, add=0, trigger -> dac_enable=0, volume=0, env_active=0.
- Config latch and retrigger: start=8, add=0, period=3, trigger, 2 ticks, write add=1/period=1 -> tick 3 gives volume 7 (old config). Retrigger -> volume reloads 8 (start unchanged) and steps upward every tick.
- Collisions: trigger and env_tick in the same cycle -> load wins, no step. reset and trigger in the same cycle -> volume=0, env_active=0. reset mid-envelope -> all state zero, no further steps until the next trigger.
